// File: rtl/adc_psram_pkg.sv
// Shared types and constants for the ADC-to-PSRAM sample packer.
package adc_psram_pkg;

    localparam int SAMPLES_PER_WORD = 5;
    localparam int TAG_W            = 4;
    localparam int SAMPLE_W         = 12;
    localparam int WORD_W           = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } packer_state_t;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [WORD_W-1:0]   word_t;

    // Word layout: tag in the top nibble, oldest sample in the low 12 bits.
    function automatic word_t pack_word(input tag_t tag,
                                        input sample_t s4, input sample_t s3,
                                        input sample_t s2, input sample_t s1,
                                        input sample_t s0);
        return {tag, s4, s3, s2, s1, s0};
    endfunction

endpackage

// File: rtl/adc_word_fifo.sv
// Show-ahead word buffer between the packer and the PSRAM write port.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module adc_word_fifo
    import adc_psram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk_PSRAM,
    input  logic  rst_n,
    input  logic  push,
    input  word_t push_data,
    input  logic  pop,
    output word_t head,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    word_t          mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // Read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Word storage.
    always_ff @(posedge clk_PSRAM) begin
        // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/adc_sample_packer.sv
// ADC sample packer: packs five 12-bit samples plus a 4-bit tag into 64-bit
// words, buffers them and issues PSRAM write requests.
// Optional build macro ADC_PACKER_TESTPATTERN_EN replaces samples with a counter.
module adc_sample_packer
    import adc_psram_pkg::*;
#(
    parameter int                ADDR_W     = 21,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                ADDR_STEP  = 4,
    parameter int                N_WORDS    = 1024,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk_PSRAM,
    input  logic              rst_n,
    input  logic              start,
    input  logic              adc_ready,
    input  logic [11:0]       adc_data,
    output logic              adc_enable,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int CNT_W = $clog2(N_WORDS + 1);

    packer_state_t    state;
    packer_state_t    state_next;
    logic             start_ok;
    logic             strobe_ok;
    logic             word_done;
    logic             last_word;
    logic [2:0]       slot_idx;
    sample_t          slots [SAMPLES_PER_WORD-1];
    tag_t             tag;
    logic [CNT_W-1:0] word_cnt;
    sample_t          sample_in;
    logic             pend_valid;
    word_t            pend_word;
    logic             fifo_full;
    logic             fifo_empty;
    word_t            fifo_head;
    logic             pop_ok;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign strobe_ok = adc_ready && (state == ST_CAPTURE);
    assign word_done = strobe_ok && (slot_idx == 3'(SAMPLES_PER_WORD - 1));
    assign last_word = word_done && (word_cnt == CNT_W'(N_WORDS - 1));
    assign pop_ok    = wr_ack && !fifo_empty;
    assign wr_req    = !fifo_empty;
    assign wr_data   = fifo_empty ? '0 : fifo_head;

`ifdef ADC_PACKER_TESTPATTERN_EN
    sample_t tp_cnt;
    logic    unused_adc_data;

    assign unused_adc_data = ^adc_data;
    assign sample_in       = tp_cnt;

    // Test-pattern sample source: counts accepted strobes from zero after start.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n)         tp_cnt <= '0;
        else if (start_ok)  tp_cnt <= '0;
        else if (strobe_ok) tp_cnt <= tp_cnt + 1'b1;
    end
`else
    assign sample_in = adc_data;
`endif

    // State register.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        adc_enable = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                adc_enable = 1'b1;
                busy       = 1'b1;
                if (last_word) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty && !pend_valid) state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_CAPTURE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sample slots, tag and word counter; the fifth sample completes the word directly.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            slot_idx <= '0;
            tag      <= '0;
            word_cnt <= '0;
            for (int i = 0; i < SAMPLES_PER_WORD - 1; i++) slots[i] <= '0;
        end else if (start_ok) begin
            slot_idx <= '0;
            tag      <= '0;
            word_cnt <= '0;
        end else if (strobe_ok) begin
            if (word_done) begin
                slot_idx <= '0;
                tag      <= tag + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                slots[slot_idx[1:0]] <= sample_in;
                slot_idx             <= slot_idx + 1'b1;
            end
        end
    end

    // One-cycle holding stage for a completed word before it enters the buffer.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
        end else begin
            pend_valid <= word_done;
            if (word_done)
                pend_word <= pack_word(tag, sample_in, slots[3], slots[2], slots[1], slots[0]);
        end
    end

    // Sticky drop flag: a word arriving at a full buffer with no pop that cycle is lost.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n)                                  overflow <= 1'b0;
        else if (start_ok)                           overflow <= 1'b0;
        else if (pend_valid && fifo_full && !wr_ack) overflow <= 1'b1;
    end

    // Write address: restarts at the base on start, advances on each accepted write.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n)        wr_addr <= BASE_ADDR;
        else if (start_ok) wr_addr <= BASE_ADDR;
        else if (pop_ok)   wr_addr <= wr_addr + ADDR_W'(ADDR_STEP);
    end

    adc_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_PSRAM (clk_PSRAM),
        .rst_n     (rst_n),
        .push      (pend_valid),
        .push_data (pend_word),
        .pop       (wr_ack),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
